// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button input path: the button vector type,
// default timing constants and the repeat FSM state encoding.
package button_conditioner_pkg;

  typedef struct packed {
    logic left;
    logic right;
    logic down;
    logic cw;
    logic ccw;
  } buttons_t;

  localparam int DEBOUNCE_TICKS_DEFAULT      = 4;
  localparam int REPEAT_DELAY_TICKS_DEFAULT  = 12;
  localparam int REPEAT_PERIOD_TICKS_DEFAULT = 4;

  localparam buttons_t REPEAT_MASK_DEFAULT = '{left: 1'b1, right: 1'b1, down: 1'b1,
                                               cw: 1'b0, ccw: 1'b0};

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HELD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  // Smallest counter width that can represent max_val itself.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Pin-side button bundle: raw pin levels and sample strobe in, conditioned
// levels out towards the ButtonFilter.
interface button_conditioner_if;
  import button_conditioner_pkg::*;

  buttons_t raw_pins;
  logic     tick;
  buttons_t clean_buttons;

  modport master (output raw_pins, output tick, input clean_buttons);
  modport slave  (input raw_pins, input tick, output clean_buttons);

endinterface

// File: rtl/button_conditioner_channel.sv
// One button: 2-flop synchronizer, tick-based debounce and an auto-repeat FSM
// that punches single-cycle gaps into a held press.
module button_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_TICKS      = DEBOUNCE_TICKS_DEFAULT,
  parameter int REPEAT_DELAY_TICKS  = REPEAT_DELAY_TICKS_DEFAULT,
  parameter int REPEAT_PERIOD_TICKS = REPEAT_PERIOD_TICKS_DEFAULT,
  parameter bit REPEAT_EN           = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_pin,
  input  logic tick,
  output logic clean
);

  localparam int RMAX = (REPEAT_DELAY_TICKS > REPEAT_PERIOD_TICKS) ?
                        REPEAT_DELAY_TICKS : REPEAT_PERIOD_TICKS;
  localparam int DW   = cnt_width(DEBOUNCE_TICKS);
  localparam int RW   = cnt_width(RMAX);

  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [DW-1:0] DB_ONE      = DW'(1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY_TICKS - 1);
  localparam logic [RW-1:0] DELAY_SAT   = RW'(REPEAT_DELAY_TICKS);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD_TICKS - 1);
  localparam logic [RW-1:0] R_ONE       = RW'(1);

  logic          sync1_r;
  logic          sync2_r;
  logic          stable_r;
  logic          gap_r;
  logic          clean_r;
  logic [DW-1:0] dcnt_r;
  logic [RW-1:0] rcnt_r;
  logic [1:0]    state_r;

  logic          stable_s;
  logic          gap_s;
  logic [DW-1:0] dcnt_s;
  logic [RW-1:0] rcnt_s;
  logic [1:0]    state_s;

  // Debounce: any agreement clears the run; only ticks advance it.
  always_comb begin
    stable_s = stable_r;
    dcnt_s   = dcnt_r;
    if (sync2_r == stable_r) begin
      dcnt_s = '0;
    end else if (tick) begin
      if (dcnt_r == DB_LAST) begin
        stable_s = sync2_r;
        dcnt_s   = '0;
      end else begin
        dcnt_s = dcnt_r + DB_ONE;
      end
    end else begin
      dcnt_s = dcnt_r;
    end
  end

  // Repeat FSM: a release overrides everything, including a due gap.
  always_comb begin
    state_s = state_r;
    rcnt_s  = rcnt_r;
    gap_s   = 1'b0;
    if (!stable_r) begin
      state_s = ST_IDLE;
      rcnt_s  = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_HELD;
          rcnt_s  = '0;
        end
        ST_HELD: begin
          if (tick && (rcnt_r != DELAY_SAT)) begin
            if (rcnt_r == DELAY_LAST) begin
              if (REPEAT_EN) begin
                state_s = ST_REPEAT;
                rcnt_s  = '0;
                gap_s   = 1'b1;
              end else begin
                rcnt_s = DELAY_SAT;
              end
            end else begin
              rcnt_s = rcnt_r + R_ONE;
            end
          end else begin
            rcnt_s = rcnt_r;
          end
        end
        ST_REPEAT: begin
          if (tick) begin
            if (rcnt_r == PERIOD_LAST) begin
              rcnt_s = '0;
              gap_s  = 1'b1;
            end else begin
              rcnt_s = rcnt_r + R_ONE;
            end
          end else begin
            rcnt_s = rcnt_r;
          end
        end
        default: begin
          state_s = ST_IDLE;
          rcnt_s  = '0;
        end
      endcase
    end
  end

  // State registers; reset drops all history including the synchronizer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      stable_r <= 1'b0;
      dcnt_r   <= '0;
      state_r  <= ST_IDLE;
      rcnt_r   <= '0;
      gap_r    <= 1'b0;
      clean_r  <= 1'b0;
    end else begin
      sync1_r  <= raw_pin;
      sync2_r  <= sync1_r;
      stable_r <= stable_s;
      dcnt_r   <= dcnt_s;
      state_r  <= state_s;
      rcnt_r   <= rcnt_s;
      gap_r    <= gap_s;
      clean_r  <= stable_r & ~gap_r;
    end
  end

  assign clean = clean_r;

endmodule

// File: rtl/button_conditioner.sv
// Conditions every raw button pin into a debounced, auto-repeating level
// for the ButtonFilter; one independent channel per button.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int       DEBOUNCE_TICKS      = DEBOUNCE_TICKS_DEFAULT,
  parameter int       REPEAT_DELAY_TICKS  = REPEAT_DELAY_TICKS_DEFAULT,
  parameter int       REPEAT_PERIOD_TICKS = REPEAT_PERIOD_TICKS_DEFAULT,
  parameter buttons_t REPEAT_MASK         = REPEAT_MASK_DEFAULT
) (
  input logic                 clk,
  input logic                 reset_n,
  button_conditioner_if.slave bus
);

  localparam int            NB       = $bits(buttons_t);
  localparam logic [NB-1:0] MASK_VEC = REPEAT_MASK;

  logic [NB-1:0] raw_vec_s;
  logic [NB-1:0] clean_vec_s;

  assign raw_vec_s         = bus.raw_pins;
  assign bus.clean_buttons = buttons_t'(clean_vec_s);

  for (genvar i = 0; i < NB; i++) begin : g_chan
    button_channel #(
      .DEBOUNCE_TICKS      (DEBOUNCE_TICKS),
      .REPEAT_DELAY_TICKS  (REPEAT_DELAY_TICKS),
      .REPEAT_PERIOD_TICKS (REPEAT_PERIOD_TICKS),
      .REPEAT_EN           (MASK_VEC[i])
    ) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .raw_pin (raw_vec_s[i]),
      .tick    (bus.tick),
      .clean   (clean_vec_s[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: hand-timed vector table and corner sequences,
// then random pins/ticks/resets against a tick-arithmetic reference model.
module tb_button_conditioner;
  import button_conditioner_pkg::*;

  localparam int            NB     = $bits(buttons_t);
  localparam int            DB     = 4;
  localparam int            DELAY  = 12;
  localparam int            PERIOD = 4;
  localparam logic [NB-1:0] MASK   = 5'b11100;

  typedef struct packed {
    logic [NB-1:0] raw;
    logic          rst_n;
    logic [15:0]   cycles;
    logic [NB-1:0] exp;
  } vec_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   ph      = 0;
  int   checks  = 0;
  int   errors  = 0;

  // Reference model state: pipeline of pin samples, accepted level, and
  // per-button count of ticks held since the debounced press.
  logic [NB-1:0] m_s1, m_s2, m_stable, m_gap, m_clean;
  int            m_cnt  [NB];
  int            m_held [NB];

  button_conditioner_if bus();

  button_conditioner #(
    .DEBOUNCE_TICKS      (DB),
    .REPEAT_DELAY_TICKS  (DELAY),
    .REPEAT_PERIOD_TICKS (PERIOD),
    .REPEAT_MASK         (buttons_t'(MASK))
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    logic [NB-1:0] raw;
    raw = bus.raw_pins;
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_gap = '0; m_clean = '0;
      for (int i = 0; i < NB; i++) begin
        m_cnt[i]  = 0;
        m_held[i] = -1;
      end
    end else begin
      m_clean = m_stable & ~m_gap;
      for (int i = 0; i < NB; i++) begin
        m_gap[i] = 1'b0;
        if (!m_stable[i]) m_held[i] = -1;
        else if (m_held[i] < 0) m_held[i] = 0;
        else if (bus.tick) begin
          m_held[i] = m_held[i] + 1;
          if (MASK[i] && m_held[i] >= DELAY && ((m_held[i] - DELAY) % PERIOD) == 0)
            m_gap[i] = 1'b1;
        end
        if (m_s2[i] == m_stable[i]) m_cnt[i] = 0;
        else if (bus.tick) begin
          m_cnt[i] = m_cnt[i] + 1;
          if (m_cnt[i] == DB) begin
            m_stable[i] = m_s2[i];
            m_cnt[i]    = 0;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
  endtask

  task automatic step(input logic tk);
    bus.tick = tk;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // One clock with the regular tick every 8th clock after reset release.
  task automatic cyc();
    logic tk;
    tk = reset_n ? (ph == 7) : 1'b1;
    step(tk);
    ph = reset_n ? (ph + 1) % 8 : 0;
  endtask

  task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: clean_buttons=%b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    vec_t vecs [0:11];
    logic saw_early;
    logic prev;
    int   rises, lows, first_low, cw_lows;

    bus.raw_pins = '0;
    bus.tick     = 1'b0;

    // Edge counts after reset release: accept at edge 32, gaps at 129/161,
    // release driven from edge 162 is accepted at edge 192.
    vecs[0]  = '{raw: 5'h00, rst_n: 1'b0, cycles: 16'd4,  exp: 5'h00};
    vecs[1]  = '{raw: 5'h1F, rst_n: 1'b0, cycles: 16'd4,  exp: 5'h00};
    vecs[2]  = '{raw: 5'h1F, rst_n: 1'b1, cycles: 16'd31, exp: 5'h00};
    vecs[3]  = '{raw: 5'h1F, rst_n: 1'b1, cycles: 16'd1,  exp: 5'h00};
    vecs[4]  = '{raw: 5'h1F, rst_n: 1'b1, cycles: 16'd1,  exp: 5'h1F};
    vecs[5]  = '{raw: 5'h1F, rst_n: 1'b1, cycles: 16'd95, exp: 5'h1F};
    vecs[6]  = '{raw: 5'h1F, rst_n: 1'b1, cycles: 16'd1,  exp: 5'h03};
    vecs[7]  = '{raw: 5'h1F, rst_n: 1'b1, cycles: 16'd1,  exp: 5'h1F};
    vecs[8]  = '{raw: 5'h1F, rst_n: 1'b1, cycles: 16'd30, exp: 5'h1F};
    vecs[9]  = '{raw: 5'h1F, rst_n: 1'b1, cycles: 16'd1,  exp: 5'h03};
    vecs[10] = '{raw: 5'h00, rst_n: 1'b1, cycles: 16'd31, exp: 5'h1F};
    vecs[11] = '{raw: 5'h00, rst_n: 1'b1, cycles: 16'd1,  exp: 5'h00};

    for (int v = 0; v < 12; v++) begin
      bus.raw_pins = buttons_t'(vecs[v].raw);
      reset_n      = vecs[v].rst_n;
      for (int c = 0; c < int'(vecs[v].cycles); c++) cyc();
      check($sformatf("vec%0d", v), bus.clean_buttons, vecs[v].exp);
    end

    // Bouncing left: 3 short presses, then steady from clock 49.
    reset_n = 1'b0; bus.raw_pins = '0; repeat (2) cyc(); reset_n = 1'b1;
    saw_early = 1'b0;
    for (int n = 1; n <= 81; n++) begin
      bus.raw_pins      = '0;
      bus.raw_pins.left = (n > 48) || ((((n - 1) / 8) % 2) == 0);
      cyc();
      if (n <= 80 && bus.clean_buttons.left) saw_early = 1'b1;
    end
    check_int("left_early_rise", int'(saw_early), 0);
    check_int("left_debounced_rise", int'(bus.clean_buttons.left), 1);

    // right repeats, cw never does; held 30 ticks past the accept tick.
    reset_n = 1'b0; bus.raw_pins = '0; bus.raw_pins.right = 1'b1; bus.raw_pins.cw = 1'b1;
    repeat (2) cyc(); reset_n = 1'b1;
    rises = 0; lows = 0; first_low = 0; cw_lows = 0; prev = 1'b1;
    for (int n = 1; n <= 274; n++) begin
      cyc();
      if (n == 33) check_int("right_rise", int'(bus.clean_buttons.right), 1);
      if (n >= 34) begin
        if (!bus.clean_buttons.right) begin
          lows++;
          if (first_low == 0) first_low = n;
        end
        if (bus.clean_buttons.right && !prev) rises++;
        if (!bus.clean_buttons.cw) cw_lows++;
      end
      prev = bus.clean_buttons.right;
    end
    check_int("right_repeat_rises", rises, 5);
    check_int("right_gap_cycles", lows, 5);
    check_int("right_first_gap_clock", first_low, 129);
    check_int("cw_gap_cycles", cw_lows, 0);

    // One-clock reset in the middle of left repeating, pin still held.
    reset_n = 1'b0; bus.raw_pins = '0; bus.raw_pins.left = 1'b1;
    repeat (2) cyc(); reset_n = 1'b1;
    repeat (130) cyc();
    reset_n = 1'b0; cyc();
    check("reset_pulse_clear", bus.clean_buttons, 5'h00);
    reset_n = 1'b1;
    repeat (32) cyc();
    check_int("left_redebounce_pending", int'(bus.clean_buttons.left), 0);
    cyc();
    check_int("left_redebounced", int'(bus.clean_buttons.left), 1);
    repeat (95) cyc();
    check_int("left_full_delay_high", int'(bus.clean_buttons.left), 1);
    cyc();
    check_int("left_full_delay_gap", int'(bus.clean_buttons.left), 0);

    // Random pins, irregular ticks and rare resets against the model.
    reset_n = 1'b0; bus.raw_pins = '0; repeat (2) cyc(); reset_n = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      logic [NB-1:0] r;
      r = bus.raw_pins;
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(0, 59) == 0) r[b] = ~r[b];
      end
      bus.raw_pins = buttons_t'(r);
      reset_n      = ($urandom_range(0, 999) != 0);
      step($urandom_range(0, 2) == 0);
      check("random", bus.clean_buttons, m_clean);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
